bitwise_op_resp: RTL and testbench

Responder-side execution unit for the bitwise-operator exercises. It accepts (opcode, a, b) requests over a valid/ready handshake and computes AND/OR/NOT/NAND/NOR/XOR/XNOR. It returns each result in order through a small output FIFO with its own valid/ready handshake. It is the DUT end that the operator stimulus benches drive and check against, and it also keeps a transaction count and a sticky illegal-opcode flag.

---
 rtl/bitwise_op_pkg.sv | 33 +++
 rtl/bitwise_op_fifo.sv | 87 ++++++++
 rtl/bitwise_op_resp.sv | 94 +++++++++
 tb/tb_bitwise_op_resp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_op_pkg.sv
// Shared types for the bitwise-operator responder: opcode set, FIFO occupancy
// states and the per-entry tag carried alongside each result.
package bitwise_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PART,
    OCC_FULL
  } occ_e;

  // Result width is a module parameter, so the package carries only the
  // width-independent part of an entry; the top wraps it with the result.
  typedef struct packed {
    op_e  op;
    logic err;
  } entry_tag_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return op == OP_ILL;
  endfunction

endpackage

// File: rtl/bitwise_op_fifo.sv
// DEPTH-entry synchronous FIFO with count/full/empty status. Occupancy is
// tracked by the count register; the EMPTY/PART/FULL state is decoded from it.
module bitwise_op_fifo
  import bitwise_op_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_next;
  occ_e              occ;
  logic              do_push;
  logic              do_pop;

  // Decode occupancy state from the count register.
  always_comb begin
    occ = OCC_PART;
    if (count == '0)
      occ = OCC_EMPTY;
    else if (count == CNT_W'(DEPTH))
      occ = OCC_FULL;
  end

  // Qualify push/pop by occupancy and compute the next count.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    count_next = count;
    case (occ)
      OCC_EMPTY: do_push = push;
      OCC_PART: begin
        do_push = push;
        do_pop  = pop;
      end
      OCC_FULL:  do_pop = pop;
      default:   ;
    endcase
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Count and pointer registers; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero until written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (occ == OCC_FULL);
  assign empty = (occ == OCC_EMPTY);

endmodule

// File: rtl/bitwise_op_resp.sv
// Responder execution unit: computes a bitwise operation on each accepted
// request and returns results in order through a small FIFO. Also keeps an
// accepted-transaction counter and a sticky illegal-opcode flag.
module bitwise_op_resp
  import bitwise_op_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    entry_tag_t       tag;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t            wr_entry;
  entry_t            rd_entry;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop;

  // Per-bit result for the request on the input bus; 4-state values pass through.
  always_comb begin
    wr_entry         = '0;
    wr_entry.tag.op  = op_e'(in_op);
    wr_entry.tag.err = is_illegal(in_op);
    case (in_op)
      OP_AND:  wr_entry.result = in_a & in_b;
      OP_OR:   wr_entry.result = in_a | in_b;
      OP_NOT:  wr_entry.result = ~in_a;
      OP_NAND: wr_entry.result = ~(in_a & in_b);
      OP_NOR:  wr_entry.result = ~(in_a | in_b);
      OP_XOR:  wr_entry.result = in_a ^ in_b;
      OP_XNOR: wr_entry.result = ~(in_a ^ in_b);
      default: wr_entry.result = '0;
    endcase
  end

  assign in_ready  = !fifo_full;
  assign out_valid = (fifo_count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_ready && !fifo_empty;

  bitwise_op_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_result = rd_entry.result;
  assign out_op     = rd_entry.tag.op;
  assign out_err    = rd_entry.tag.err;

  // Transaction counter (wrapping) and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count  <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      txn_count <= txn_count + 1'b1;
      if (wr_entry.tag.err) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitwise_op_resp.sv
// Scoreboard bench for bitwise_op_resp: accepted requests push a reference
// result into a queue; a monitor compares the FIFO head and status each cycle.
module tb_bitwise_op_resp;

  localparam int W  = 3;
  localparam int D  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [2:0]    out_op;
  logic          out_err;
  logic          err_sticky;
  logic [CW-1:0] txn_count;

  always #5 clk = ~clk;

  bitwise_op_resp #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .txn_count  (txn_count)
  );

  typedef struct {
    logic [2:0]   op;
    logic         err;
    logic [W-1:0] res;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [CW-1:0] m_cnt = '0;
  logic          m_err = 1'b0;
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: no acceptance within cycle budget at %0t", name, $time);
  endtask

  // Reference behaviour: each opcode's meaning as a bitwise rule on a and b.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    r.op  = op;
    r.err = 1'b0;
    case (op)
      3'd0: r.res = a & b;
      3'd1: r.res = a | b;
      3'd2: r.res = ~a;
      3'd3: r.res = ~(a & b);
      3'd4: r.res = ~(a | b);
      3'd5: r.res = a ^ b;
      3'd6: r.res = ~(a ^ b);
      default: begin
        r.res = '0;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Monitor: status vs. model occupancy, head vs. queue front, then record accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {15'd0, in_ready}, {15'd0, q.size() != D});
      chk("out_valid", {15'd0, out_valid}, {15'd0, q.size() != 0});
      chk("txn_count", txn_count, m_cnt);
      chk("err_sticky", {15'd0, err_sticky}, {15'd0, m_err});
      if (out_valid && q.size() > 0) begin
        e = q[0];
        chk("out_result", {13'd0, out_result}, {13'd0, e.res});
        chk("out_op", {13'd0, out_op}, {13'd0, e.op});
        chk("out_err", {15'd0, out_err}, {15'd0, e.err});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_a, in_b));
        m_cnt = m_cnt + 1'b1;
        if (in_op == 3'd7) m_err = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_out_result"}, {13'd0, out_result}, 16'd0);
    chk({tag, "_out_op"}, {13'd0, out_op}, 16'd0);
    chk({tag, "_out_err"}, {15'd0, out_err}, 16'd0);
    chk({tag, "_err_sticky"}, {15'd0, err_sticky}, 16'd0);
    chk({tag, "_txn_count"}, txn_count, 16'd0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    timeout("send");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // All opcodes back to back with a=011, b=101.
    out_ready = 1'b1;
    for (int op = 0; op < 7; op++) send(3'(op), 3'b011, 3'b101);
    idle(3);
    chk("ops_txn_count", txn_count, 16'd7);

    // Unknown operand bits propagate through the operators.
    send(3'd0, 3'bxxx, 3'b101);
    send(3'd1, 3'bxxx, 3'b000);
    send(3'd2, 3'bx0x, 3'b000);
    idle(3);

    // Backpressure: fill, hold in_valid, release out_ready for one cycle.
    out_ready = 1'b0;
    send(3'd0, 3'b110, 3'b011);
    send(3'd5, 3'b101, 3'b111);
    @(negedge clk);
    chk("bp_full_in_ready", {15'd0, in_ready}, 16'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd4; in_a = 3'b001; in_b = 3'b010;
    idle(2);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_slot_freed", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Simultaneous push and pop with one entry held.
    out_ready = 1'b0;
    send(3'd6, 3'b100, 3'b110);
    in_valid = 1'b1; in_op = 3'd3; in_a = 3'b111; in_b = 3'b010;
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pp_out_valid", {15'd0, out_valid}, 16'd1);
    chk("pp_in_ready", {15'd0, in_ready}, 16'd1);
    chk("pp_head_op", {13'd0, out_op}, 16'd3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);

    // Illegal opcode.
    send(3'd7, 3'b111, 3'b111);
    idle(3);
    chk("ill_sticky", {15'd0, err_sticky}, 16'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = 3'($urandom);
      in_b      = 3'($urandom);
      idle(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-cycle with a full FIFO and the sticky flag set.
    out_ready = 1'b0;
    send(3'd7, 3'b000, 3'b000);
    send(3'd1, 3'b010, 3'b001);
    @(negedge clk);
    chk("pre_rst_full", {15'd0, in_ready}, 16'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    q.delete();
    m_cnt = '0;
    m_err = 1'b0;
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(3'd5, 3'b011, 3'b110);
    idle(3);
    chk("post_rst_txn_count", txn_count, 16'd1);

    // Drain and confirm every expected result was observed.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("scoreboard_empty", 16'(q.size()), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
